// File: rtl/unit_pkg.sv
// Shared definitions for lane units: FSM encoding, per-type stat tables, regen period
// and type-select helpers. UNIT_REGEN_EN (in lane_unit) consumes REGEN_PERIOD.
package unit_pkg;

    // ST_IDLE: slot empty | ST_DEPLOY: loading stats | ST_ALIVE: walking/fighting | ST_DYING: death timer
    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_DEPLOY = 2'd1,
        ST_ALIVE  = 2'd2,
        ST_DYING  = 2'd3
    } unit_state_e;

    localparam int REGEN_PERIOD = 8;

    function automatic int hp_max(input logic [2:0] t);
        case (t)
            3'd1, 3'd2, 3'd3: return 255;
            3'd4:             return 200;
            3'd5:             return 160;
            3'd6:             return 120;
            3'd7:             return 96;
            default:          return 0;
        endcase
    endfunction

    function automatic int power_of(input logic [2:0] t);
        case (t)
            3'd1:    return 32;
            3'd2:    return 64;
            3'd3:    return 128;
            3'd4:    return 48;
            3'd5:    return 96;
            3'd6:    return 160;
            3'd7:    return 200;
            default: return 0;
        endcase
    endfunction

    function automatic int cooldown_of(input logic [2:0] t);
        case (t)
            3'd2:    return 1;
            3'd3:    return 3;
            3'd4:    return 1;
            3'd5:    return 2;
            3'd6:    return 4;
            3'd7:    return 6;
            default: return 0;
        endcase
    endfunction

    function automatic logic sel_is_onehot(input logic [6:0] v);
        return (v != 7'd0) && ((v & (v - 7'd1)) == 7'd0);
    endfunction

    function automatic logic [2:0] onehot_to_type(input logic [6:0] v);
        logic [2:0] idx;
        idx = 3'd0;
        for (int i = 0; i < 7; i++) begin
            if (v[i]) idx = 3'(i + 1);
        end
        return idx;
    endfunction

endpackage

// File: rtl/lane_unit_if.sv
// Controller-to-unit bundle: purchase, tick/damage strobes, enemy front, and unit status.
interface lane_unit_if #(
    parameter int POS_W   = 9,
    parameter int HP_W    = 8,
    parameter int DMG_W   = 8,
    parameter int N_TYPES = 3
);
    localparam int TYPE_W = $clog2(N_TYPES + 1);

    logic               purchase;
    logic [N_TYPES-1:0] typeSel;
    logic               purchaseAck;
    logic               moveSCEN;
    logic               damageSCEN;
    logic [DMG_W-1:0]   damageIn;
    logic [POS_W-1:0]   enemyFront;
    logic [POS_W-1:0]   position;
    logic [DMG_W-1:0]   damageOut;
    logic [TYPE_W-1:0]  unitType;
    logic [HP_W-1:0]    health;
    logic               dying;

    modport master (
        output purchase, typeSel, moveSCEN, damageSCEN, damageIn, enemyFront,
        input  purchaseAck, position, damageOut, unitType, health, dying
    );

    modport slave (
        input  purchase, typeSel, moveSCEN, damageSCEN, damageIn, enemyFront,
        output purchaseAck, position, damageOut, unitType, health, dying
    );
endinterface

// File: rtl/unit_cooldown.sv
// Loadable down-counter with zero flag; used for attack cooldown and the death timer.
module unit_cooldown #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         i_load,
    input  logic [W-1:0] i_load_val,
    input  logic         i_dec,
    output logic         o_zero
);
    logic [W-1:0] r_count;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_count <= '0;
        end else if (i_load) begin
            r_count <= i_load_val;
        end else if (i_dec && (r_count != '0)) begin
            r_count <= r_count - 1'b1;
        end
    end

    assign o_zero = (r_count == '0);
endmodule

// File: rtl/lane_unit.sv
// One battlefield unit slot: purchase, deploy, walk/attack along the lane, take damage, timed death.
// Optional health regeneration on quiet ticks when UNIT_REGEN_EN is defined.
module lane_unit
    import unit_pkg::*;
#(
    parameter int               POS_W        = 9,
    parameter int               HP_W         = 8,
    parameter int               DMG_W        = 8,
    parameter int               N_TYPES      = 3,
    parameter int               DIR          = 0,
    parameter logic [POS_W-1:0] SPAWN_POS    = (DIR == 0) ? {POS_W{1'b1}} : {POS_W{1'b0}},
    parameter int               RANGE        = 0,
    parameter int               DEATH_CYCLES = 10
) (
    input logic        clk,
    input logic        reset,
    lane_unit_if.slave bus
);
    localparam int TYPE_W = $clog2(N_TYPES + 1);
    localparam int DTH_W  = (DEATH_CYCLES > 1) ? $clog2(DEATH_CYCLES) : 1;
    localparam int CD_W   = 8;
    localparam int CMP_W  = (HP_W > DMG_W) ? HP_W : DMG_W;
    localparam logic [POS_W:0]   L_RANGE    = (POS_W + 1)'(RANGE);
    localparam logic [DTH_W-1:0] L_DTH_LOAD = DTH_W'(DEATH_CYCLES - 1);

    unit_state_e r_state;
    unit_state_e w_state_nxt;

    logic [2:0]        r_type;
    logic [POS_W-1:0]  r_pos;
    logic [HP_W-1:0]   r_health;
    logic [DMG_W-1:0]  r_power;
    logic [DMG_W-1:0]  r_dmg_out;
    logic [TYPE_W-1:0] r_unit_type;
    logic              r_ack;

    logic [6:0]        w_sel_wide;
    logic              w_sel_valid;
    logic [2:0]        w_sel_idx;
    logic [HP_W-1:0]   w_hp_max;
    logic [DMG_W-1:0]  w_power;
    logic [CD_W-1:0]   w_cd_load_val;
    logic [POS_W-1:0]  w_pos_step;
    logic              w_in_range;
    logic              w_lethal_hit;
    logic              w_cd_zero;
    logic              w_dth_zero;
    logic              w_accept;
    logic              w_deploy;
    logic              w_die;
    logic              w_to_idle;
    logic              w_alive_move;
    logic              w_attack;
    logic              w_cool_tick;
    logic              w_regen_inc;

    assign w_sel_wide   = 7'(bus.typeSel);
    assign w_sel_valid  = sel_is_onehot(w_sel_wide);
    assign w_sel_idx    = onehot_to_type(w_sel_wide);
    assign w_hp_max     = HP_W'(hp_max(r_type));
    assign w_power      = DMG_W'(power_of(r_type));
    assign w_lethal_hit = bus.damageSCEN && (CMP_W'(r_health) <= CMP_W'(bus.damageIn));

    // Range check is widened by one bit so enemyFront+RANGE never wraps.
    always_comb begin
        w_in_range = 1'b0;
        w_pos_step = r_pos;
        if (DIR == 0) begin
            w_in_range = ({1'b0, bus.enemyFront} + L_RANGE) >= {1'b0, r_pos};
            if (r_pos != '0) w_pos_step = r_pos - 1'b1;
        end else begin
            w_in_range = ({1'b0, r_pos} + L_RANGE) >= {1'b0, bus.enemyFront};
            if (r_pos != '1) w_pos_step = r_pos + 1'b1;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) r_state <= ST_IDLE;
        else       r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt  = r_state;
        w_accept     = 1'b0;
        w_deploy     = 1'b0;
        w_die        = 1'b0;
        w_to_idle    = 1'b0;
        w_alive_move = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (bus.purchase && w_sel_valid) begin
                    w_state_nxt = ST_DEPLOY;
                    w_accept    = 1'b1;
                end
            end
            ST_DEPLOY: begin
                w_state_nxt = ST_ALIVE;
                w_deploy    = 1'b1;
            end
            ST_ALIVE: begin
                if (w_lethal_hit) begin
                    w_state_nxt = ST_DYING;
                    w_die       = 1'b1;
                end else begin
                    w_alive_move = bus.moveSCEN;
                end
            end
            ST_DYING: begin
                if (w_dth_zero) begin
                    w_state_nxt = ST_IDLE;
                    w_to_idle   = 1'b1;
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
                w_to_idle   = 1'b1;
            end
        endcase
    end

    assign w_attack      = w_alive_move && w_in_range && w_cd_zero;
    assign w_cool_tick   = w_alive_move && w_in_range && !w_cd_zero;
    assign w_cd_load_val = w_deploy ? '0 : CD_W'(cooldown_of(r_type));

    unit_cooldown #(.W(CD_W)) u_attack_cd (
        .clk        (clk),
        .reset      (reset),
        .i_load     (w_deploy || w_attack),
        .i_load_val (w_cd_load_val),
        .i_dec      (w_cool_tick),
        .o_zero     (w_cd_zero)
    );

    unit_cooldown #(.W(DTH_W)) u_death_timer (
        .clk        (clk),
        .reset      (reset),
        .i_load     (w_die),
        .i_load_val (L_DTH_LOAD),
        .i_dec      (r_state == ST_DYING),
        .o_zero     (w_dth_zero)
    );

`ifdef UNIT_REGEN_EN
    localparam int RG_W = $clog2(REGEN_PERIOD + 1);
    logic [RG_W-1:0] r_regen;

    assign w_regen_inc = (r_state == ST_ALIVE) && bus.moveSCEN && !bus.damageSCEN &&
                         !w_in_range && (r_regen == RG_W'(REGEN_PERIOD - 1));

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_regen <= '0;
        end else if ((r_state != ST_ALIVE) || bus.damageSCEN || (bus.moveSCEN && w_in_range)) begin
            r_regen <= '0;
        end else if (bus.moveSCEN) begin
            r_regen <= w_regen_inc ? '0 : r_regen + 1'b1;
        end
    end
`else
    assign w_regen_inc = 1'b0;
`endif

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_type      <= '0;
            r_pos       <= SPAWN_POS;
            r_health    <= '0;
            r_power     <= '0;
            r_dmg_out   <= '0;
            r_unit_type <= '0;
            r_ack       <= 1'b0;
        end else begin
            r_ack <= w_accept;
            if (w_accept) r_type <= w_sel_idx;

            if (w_deploy) begin
                r_health    <= w_hp_max;
                r_power     <= w_power;
                r_unit_type <= TYPE_W'(r_type);
                r_dmg_out   <= '0;
            end else if (w_die || w_to_idle) begin
                r_health    <= '0;
                r_unit_type <= '0;
                r_dmg_out   <= '0;
                if (w_to_idle) r_pos <= SPAWN_POS;
            end else if (r_state == ST_ALIVE) begin
                if (bus.damageSCEN) begin
                    r_health <= r_health - HP_W'(bus.damageIn);
                end else if (w_regen_inc && (r_health < w_hp_max)) begin
                    r_health <= r_health + 1'b1;
                end
                if (w_alive_move) begin
                    if (!w_in_range) begin
                        r_pos     <= w_pos_step;
                        r_dmg_out <= '0;
                    end else if (w_cd_zero) begin
                        r_dmg_out <= r_power;
                    end else begin
                        r_dmg_out <= '0;
                    end
                end
            end
        end
    end

    assign bus.purchaseAck = r_ack;
    assign bus.position    = r_pos;
    assign bus.damageOut   = r_dmg_out;
    assign bus.unitType    = r_unit_type;
    assign bus.health      = r_health;
    assign bus.dying       = (r_state == ST_DYING);
endmodule

// File: tb/tb_lane_unit.sv
// Directed bench for lane_unit with default parameters (DIR=0, SPAWN_POS=511, RANGE=0, DEATH_CYCLES=10).
module tb_lane_unit;
    logic clk;
    logic reset;
    int   total;
    int   bad;

`ifdef UNIT_REGEN_EN
    localparam int HP_A = 252;
    localparam int HP_B = 255;
`else
    localparam int HP_A = 250;
    localparam int HP_B = 250;
`endif

    lane_unit_if #(.POS_W(9), .HP_W(8), .DMG_W(8), .N_TYPES(3)) bus ();

    lane_unit dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    initial begin
        total = 0;
        bad   = 0;
        reset = 1'b1;
        bus.purchase   = 1'b0;
        bus.typeSel    = 3'b000;
        bus.moveSCEN   = 1'b0;
        bus.damageSCEN = 1'b0;
        bus.damageIn   = 8'd0;
        bus.enemyFront = 9'd0;

        #12;
        chk("rst_position", 32'(bus.position), 511);
        chk("rst_health", 32'(bus.health), 0);
        chk("rst_unittype", 32'(bus.unitType), 0);
        chk("rst_damageout", 32'(bus.damageOut), 0);
        chk("rst_dying", 32'(bus.dying), 0);
        chk("rst_ack", 32'(bus.purchaseAck), 0);
        reset = 1'b0;
        tick();

        // Illegal selects
        bus.typeSel = 3'b110; bus.purchase = 1'b1;
        tick();
        chk("ack_multihot", 32'(bus.purchaseAck), 0);
        bus.typeSel = 3'b000;
        tick();
        chk("ack_zerohot", 32'(bus.purchaseAck), 0);
        bus.purchase = 1'b0;
        tick();
        chk("ack_zerohot_late", 32'(bus.purchaseAck), 0);

        // Valid purchase of type 2
        bus.typeSel = 3'b010; bus.purchase = 1'b1;
        tick();
        chk("ack_pulse", 32'(bus.purchaseAck), 1);
        chk("deploy_unittype", 32'(bus.unitType), 0);
        bus.purchase = 1'b0;
        tick();
        chk("ack_drop", 32'(bus.purchaseAck), 0);
        chk("alive_unittype", 32'(bus.unitType), 2);
        chk("alive_health", 32'(bus.health), 255);
        chk("alive_position", 32'(bus.position), 511);

        // Walk to the enemy and attack with cooldown 1
        bus.enemyFront = 9'd500; bus.moveSCEN = 1'b1;
        repeat (11) tick();
        chk("walk_position", 32'(bus.position), 500);
        chk("walk_damageout", 32'(bus.damageOut), 0);
        tick();
        chk("atk1", 32'(bus.damageOut), 64);
        tick();
        chk("cooldown", 32'(bus.damageOut), 0);
        tick();
        chk("atk2", 32'(bus.damageOut), 64);
        bus.moveSCEN = 1'b0;
        tick();
        chk("dmg_hold", 32'(bus.damageOut), 64);
        chk("atk_position", 32'(bus.position), 500);

        bus.damageSCEN = 1'b1; bus.damageIn = 8'd5;
        tick();
        bus.damageSCEN = 1'b0;
        chk("hit_health", 32'(bus.health), 250);

        bus.typeSel = 3'b001; bus.purchase = 1'b1;
        tick();
        chk("ack_alive", 32'(bus.purchaseAck), 0);
        chk("alive_type_kept", 32'(bus.unitType), 2);
        bus.purchase = 1'b0;

        // Out-of-range walking: regen window
        bus.enemyFront = 9'd0; bus.moveSCEN = 1'b1;
        repeat (16) tick();
        chk("regen16_position", 32'(bus.position), 484);
        chk("regen16_health", 32'(bus.health), HP_A);
        chk("regen16_damageout", 32'(bus.damageOut), 0);
        repeat (40) tick();
        bus.moveSCEN = 1'b0;
        chk("regen56_position", 32'(bus.position), 444);
        chk("regen_saturate", 32'(bus.health), HP_B);

        bus.damageSCEN = 1'b1; bus.damageIn = 8'(HP_B - 40);
        tick();
        bus.damageSCEN = 1'b0;
        chk("health40", 32'(bus.health), 40);

        // Re-engage: cooldown still 1 from the last attack
        bus.enemyFront = 9'd444; bus.moveSCEN = 1'b1;
        tick();
        chk("reengage_cool", 32'(bus.damageOut), 0);
        tick();
        chk("atk3", 32'(bus.damageOut), 64);

        // Lethal hit with a simultaneous move that would otherwise step
        bus.enemyFront = 9'd0; bus.damageSCEN = 1'b1; bus.damageIn = 8'd40;
        tick();
        bus.moveSCEN = 1'b0; bus.damageSCEN = 1'b0; bus.damageIn = 8'd0;
        chk("die_dying", 32'(bus.dying), 1);
        chk("die_health", 32'(bus.health), 0);
        chk("die_unittype", 32'(bus.unitType), 0);
        chk("die_damageout", 32'(bus.damageOut), 0);
        chk("die_position", 32'(bus.position), 444);

        bus.typeSel = 3'b001; bus.purchase = 1'b1;
        tick();
        chk("ack_dying", 32'(bus.purchaseAck), 0);
        bus.purchase = 1'b0;
        repeat (8) tick();
        chk("dying_last", 32'(bus.dying), 1);
        tick();
        chk("dying_done", 32'(bus.dying), 0);
        chk("idle_position", 32'(bus.position), 511);

        // First IDLE cycle purchase of type 3
        bus.typeSel = 3'b100; bus.purchase = 1'b1;
        tick();
        chk("ack_type3", 32'(bus.purchaseAck), 1);
        bus.purchase = 1'b0;
        tick();
        chk("type3_unittype", 32'(bus.unitType), 3);
        chk("type3_health", 32'(bus.health), 255);
        bus.enemyFront = 9'd511; bus.moveSCEN = 1'b1;
        tick();
        chk("type3_atk", 32'(bus.damageOut), 128);
        tick();
        chk("type3_cool", 32'(bus.damageOut), 0);

        bus.enemyFront = 9'd0;
        repeat (211) tick();
        bus.moveSCEN = 1'b0;
        chk("walk300", 32'(bus.position), 300);

        // Asynchronous reset between clock edges
        #3;
        reset = 1'b1;
        #1;
        chk("arst_position", 32'(bus.position), 511);
        chk("arst_health", 32'(bus.health), 0);
        chk("arst_unittype", 32'(bus.unitType), 0);
        chk("arst_dying", 32'(bus.dying), 0);
        #3;
        reset = 1'b0;
        tick();
        chk("post_rst_unittype", 32'(bus.unitType), 0);
        chk("post_rst_ack", 32'(bus.purchaseAck), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
